// File: rtl/ram_responder_if.sv
// ram_responder_if: request/response bundle between the RAM arbiter
// (master) and the RAM model (slave). It carries the Ren/Wen request
// strobes, the byte address, the write data, the registered read data
// and the busy stall flag.
interface ram_responder_if;
  logic        Ren;
  logic        Wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        busy_o;

  modport master (
    output Ren, Wen, ramaddr, ramstore,
    input  ramload, busy_o
  );

  modport slave (
    input  Ren, Wen, ramaddr, ramstore,
    output ramload, busy_o
  );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: single-port, word-addressed 32-bit RAM model with
// programmable wait states, sitting at the memory end of the arbiter.
// Each request is captured in IDLE and held in WAIT for the configured
// number of wait cycles. The access itself happens on the edge that
// enters DONE.
// Optional feature: define RAM_LATENCY_EN to honour LAT. Otherwise LAT
// is treated as 0 and every access goes straight from IDLE to DONE.
module ram_responder #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic            CLK,
  input  logic            RST,
  ram_responder_if.slave  bus
);

`ifdef RAM_LATENCY_EN
  localparam int LAT_EFF = LAT;
`else
  localparam int LAT_EFF = 0;
`endif
  localparam logic [3:0] LAT_CNT = 4'(LAT_EFF);
  localparam int         DEPTH   = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         data_q, data_d;
  logic                wr_q, wr_d;
  logic [31:0]         ramload_q, ramload_d;
  logic                mem_we;
  logic [31:0]         mem [DEPTH];

  logic req;
  assign req = bus.Ren | bus.Wen;

  // Address bits outside the word index are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ramaddr[31:ADDR_W+2], bus.ramaddr[1:0]};

  // Next-state logic: capture in IDLE, count down in WAIT, access on entering DONE.
  // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    wr_d      = wr_q;
    ramload_d = ramload_q;
    mem_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d  = bus.ramaddr[ADDR_W+1:2];
          data_d = bus.ramstore;
          wr_d   = bus.Wen;              // Wen wins when both are high
          cnt_d  = LAT_CNT;
          state_d = (LAT_CNT != 4'd0) ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;             // initiator withdrew: abort, no access
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;        // one-cycle completion, inputs ignored
      default: state_d = ST_IDLE;
    endcase

    // The access uses the captured values. With zero wait states these are
    // the values being captured on this same edge.
    if (state_d == ST_DONE) begin
      if (wr_d) mem_we    = ~RST;
      else      ramload_d = mem[idx_d];
    end
  end

  // Control and capture registers; asynchronous reset aborts any access.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      data_q    <= 32'h0;
      wr_q      <= 1'b0;
      ramload_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      ramload_q <= ramload_d;
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; clearing it would defeat RAM inference and the contents are defined only by writes.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[idx_d] <= data_d;
  end

  assign bus.ramload = ramload_q;
  assign bus.busy_o  = req & (state_q != ST_DONE) & ~RST;

endmodule
